// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch-address sequencer with conditional branches,
// register-indirect jumps, calls/returns through a small circular
// return-address stack, stall and sticky halt.
module pc_sequencer #(
  parameter int                 ADDR_W    = 16,
  parameter int                 OFF_W     = 9,
  parameter int                 RAS_DEPTH = 4,
  parameter logic [ADDR_W-1:0]  RESET_VEC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              br_valid,
  input  logic [1:0]        br_type,
  input  logic [2:0]        cond,
  input  logic [2:0]        flags,
  input  logic [OFF_W-1:0]  offset,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] br_pc,
  input  logic              halt,
  output logic [ADDR_W-1:0] pc,
  output logic              taken,
  output logic              flush,
  output logic              halted,
  output logic              ras_err
);

  localparam int PW = (RAS_DEPTH > 2) ? $clog2(RAS_DEPTH) : 1;

  localparam logic [1:0] BT_B    = 2'b00;
  localparam logic [1:0] BT_BR   = 2'b01;
  localparam logic [1:0] BT_CALL = 2'b10;
  localparam logic [1:0] BT_RET  = 2'b11;

  // State
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              flush_q, flush_d;
  logic              halted_q, halted_d;
  logic              err_q, err_d;
  logic [PW-1:0]     ptr_q, ptr_d;      // next write slot; top is ptr_q-1
  logic [PW:0]       cnt_q, cnt_d;      // valid entries, saturates at RAS_DEPTH
  logic [ADDR_W-1:0] ras_q [RAS_DEPTH];

  // Decode helpers
  logic              flg_n, flg_v, flg_z;
  logic              met;
  logic              eligible;
  logic              is_call, is_ret;
  logic              ras_empty, ras_full;
  logic              push, pop;
  logic              overflow, underflow;
  logic [PW-1:0]     top_idx;
  logic [ADDR_W-1:0] off_sx;
  logic [ADDR_W-1:0] imm_tgt;
  logic [ADDR_W-1:0] ret_addr;
  logic [ADDR_W-1:0] target;

  assign flg_n = flags[2];
  assign flg_v = flags[1];
  assign flg_z = flags[0];

  // Condition-code decode
  always_comb begin
    met = 1'b0;
    case (cond)
      3'b000: met = ~flg_z;
      3'b001: met = flg_z;
      3'b010: met = ~flg_z & ~flg_n;
      3'b011: met = flg_n;
      3'b100: met = flg_z | (~flg_z & ~flg_n);
      3'b101: met = flg_z | flg_n;
      3'b110: met = flg_v;
      3'b111: met = 1'b1;
    endcase
  end

  // Word offset sign-extended to address width, then scaled to bytes
  assign off_sx   = ADDR_W'($signed(offset));
  assign imm_tgt  = br_pc + ADDR_W'(2) + (off_sx << 1);
  assign ret_addr = br_pc + ADDR_W'(2);

  assign is_call   = (br_type == BT_CALL);
  assign is_ret    = (br_type == BT_RET);
  assign ras_empty = (cnt_q == '0);
  assign ras_full  = (cnt_q == (PW+1)'(RAS_DEPTH));
  assign top_idx   = ptr_q - PW'(1);

  // A branch that would redirect if nothing blocks it; halt and stall
  // both veto, and reset forces it off.
  assign eligible = rst_n & br_valid & met & ~stall & ~halted_q & ~halt;

  // A RET on an empty stack is demoted to fall-through
  assign taken     = eligible & ~(is_ret & ras_empty);
  assign push      = taken & is_call;
  assign pop       = taken & is_ret;
  assign overflow  = push & ras_full;
  assign underflow = eligible & is_ret & ras_empty;

  // Redirect target selection by branch type
  always_comb begin
    target = imm_tgt;
    case (br_type)
      BT_B:    target = imm_tgt;
      BT_BR:   target = rs_addr;
      BT_CALL: target = imm_tgt;
      BT_RET:  target = ras_q[top_idx];
    endcase
  end

  // Next-state: pc priority hold > redirect > sequential, plus RAS pointers
  always_comb begin
    pc_d     = pc_q + ADDR_W'(2);
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    flush_d  = taken;
    err_d    = overflow | underflow;
    halted_d = halted_q | (halt & ~stall);

    if (halted_q || halt || stall) begin
      pc_d = pc_q;
    end else if (taken) begin
      pc_d = target;
    end

    if (push) begin
      ptr_d = ptr_q + PW'(1);
      if (!ras_full) cnt_d = cnt_q + (PW+1)'(1);
    end else if (pop) begin
      ptr_d = ptr_q - PW'(1);
      cnt_d = cnt_q - (PW+1)'(1);
    end
  end

  // Control registers with synchronous reset; reset empties the stack
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q     <= RESET_VEC;
      flush_q  <= 1'b0;
      halted_q <= 1'b0;
      err_q    <= 1'b0;
      ptr_q    <= '0;
      cnt_q    <= '0;
    end else begin
      pc_q     <= pc_d;
      flush_q  <= flush_d;
      halted_q <= halted_d;
      err_q    <= err_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Stack storage; when full the write slot is the oldest entry, so a
  // push overwrites it circularly. Contents need no reset: count gates use.
  always_ff @(posedge clk) begin
    if (rst_n && push) ras_q[ptr_q] <= ret_addr;
  end

  assign pc      = pc_q;
  assign flush   = flush_q;
  assign halted  = halted_q;
  assign ras_err = err_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed scenarios with a scoreboard of expected
// post-edge state pushed at drive time and popped after each edge.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        br_valid;
  logic [1:0]  br_type;
  logic [2:0]  cond;
  logic [2:0]  flags;
  logic [8:0]  offset;
  logic [15:0] rs_addr;
  logic [15:0] br_pc;
  logic        halt;
  logic [15:0] pc;
  logic        taken;
  logic        flush;
  logic        halted;
  logic        ras_err;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    string       tag;
    logic [15:0] pc;
    logic        fl;
    logic        err;
    logic        hlt;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  pc_sequencer dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .stall    (stall),
    .br_valid (br_valid),
    .br_type  (br_type),
    .cond     (cond),
    .flags    (flags),
    .offset   (offset),
    .rs_addr  (rs_addr),
    .br_pc    (br_pc),
    .halt     (halt),
    .pc       (pc),
    .taken    (taken),
    .flush    (flush),
    .halted   (halted),
    .ras_err  (ras_err)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic drv(input logic v, input logic [1:0] t, input logic [2:0] c,
                     input logic [2:0] f, input logic [8:0] o, input logic [15:0] rs,
                     input logic [15:0] bpc, input logic s, input logic h);
    br_valid = v; br_type = t; cond = c; flags = f; offset = o;
    rs_addr = rs; br_pc = bpc; stall = s; halt = h;
  endtask

  task automatic idle();
    drv(1'b0, 2'b00, 3'b000, 3'b000, 9'h000, 16'h0000, 16'h0000, 1'b0, 1'b0);
  endtask

  // Check combinational taken, queue expected post-edge state, clock, compare
  task automatic cyc(input string tag, input logic et, input logic [15:0] epc,
                     input logic efl, input logic eerr, input logic ehlt);
    exp_t e;
    #1;
    chk({tag, ".taken"}, 32'(taken), 32'(et));
    e.tag = tag; e.pc = epc; e.fl = efl; e.err = eerr; e.hlt = ehlt;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk({tag, ".sb_empty"}, 32'(1), 32'(0));
    end else begin
      e = sb.pop_front();
      chk({e.tag, ".pc"},      32'(pc),      32'(e.pc));
      chk({e.tag, ".flush"},   32'(flush),   32'(e.fl));
      chk({e.tag, ".ras_err"}, 32'(ras_err), 32'(e.err));
      chk({e.tag, ".halted"},  32'(halted),  32'(e.hlt));
    end
  endtask

  initial begin
    // Reset overrides a taken-eligible branch plus halt/stall
    rst_n = 1'b0;
    drv(1'b1, 2'b00, 3'b111, 3'b000, 9'h1FD, 16'h0000, 16'h0010, 1'b0, 1'b0);
    cyc("rst_br", 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    drv(1'b1, 2'b01, 3'b111, 3'b000, 9'h000, 16'hBEEF, 16'h0000, 1'b1, 1'b1);
    cyc("rst_hs", 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);

    // Free run
    rst_n = 1'b1;
    idle();
    cyc("run1", 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0);
    cyc("run2", 1'b0, 16'h0004, 1'b0, 1'b0, 1'b0);
    cyc("run3", 1'b0, 16'h0006, 1'b0, 1'b0, 1'b0);

    // B, cond 001: Z=1 taken to 0x000C, then Z=0 falls through
    drv(1'b1, 2'b00, 3'b001, 3'b001, 9'h1FD, 16'h0000, 16'h0010, 1'b0, 1'b0);
    cyc("b_z1", 1'b1, 16'h000C, 1'b1, 1'b0, 1'b0);
    idle();
    cyc("b_idle", 1'b0, 16'h000E, 1'b0, 1'b0, 1'b0);
    drv(1'b1, 2'b00, 3'b001, 3'b000, 9'h1FD, 16'h0000, 16'h0010, 1'b0, 1'b0);
    cyc("b_z0", 1'b0, 16'h0010, 1'b0, 1'b0, 1'b0);

    // Other condition codes
    drv(1'b1, 2'b01, 3'b010, 3'b000, 9'h000, 16'h0200, 16'h0000, 1'b0, 1'b0);
    cyc("c010", 1'b1, 16'h0200, 1'b1, 1'b0, 1'b0);
    drv(1'b1, 2'b01, 3'b011, 3'b000, 9'h000, 16'h0BAD, 16'h0000, 1'b0, 1'b0);
    cyc("c011", 1'b0, 16'h0202, 1'b0, 1'b0, 1'b0);
    drv(1'b1, 2'b00, 3'b110, 3'b010, 9'h000, 16'h0000, 16'h0300, 1'b0, 1'b0);
    cyc("c110", 1'b1, 16'h0302, 1'b1, 1'b0, 1'b0);
    drv(1'b1, 2'b01, 3'b100, 3'b100, 9'h000, 16'h0BAD, 16'h0000, 1'b0, 1'b0);
    cyc("c100", 1'b0, 16'h0304, 1'b0, 1'b0, 1'b0);
    drv(1'b1, 2'b01, 3'b101, 3'b100, 9'h000, 16'h0400, 16'h0000, 1'b0, 1'b0);
    cyc("c101", 1'b1, 16'h0400, 1'b1, 1'b0, 1'b0);

    // CALL then RET back-to-back
    drv(1'b1, 2'b10, 3'b111, 3'b000, 9'h010, 16'h0000, 16'h0100, 1'b0, 1'b0);
    cyc("call", 1'b1, 16'h0122, 1'b1, 1'b0, 1'b0);
    drv(1'b1, 2'b11, 3'b111, 3'b000, 9'h000, 16'h0000, 16'h0000, 1'b0, 1'b0);
    cyc("ret", 1'b1, 16'h0102, 1'b1, 1'b0, 1'b0);

    // RET on empty stack: fall through and flag underflow
    cyc("ret_empty", 1'b0, 16'h0104, 1'b0, 1'b1, 1'b0);
    drv(1'b1, 2'b11, 3'b000, 3'b001, 9'h000, 16'h0000, 16'h0000, 1'b0, 1'b0);
    cyc("ret_nomet", 1'b0, 16'h0106, 1'b0, 1'b0, 1'b0);

    // Five CALLs overflow a 4-deep stack
    for (int i = 0; i < 5; i++) begin
      drv(1'b1, 2'b10, 3'b111, 3'b000, 9'h000, 16'h0000, 16'(16'h1000 + i * 16'h0100), 1'b0, 1'b0);
      cyc($sformatf("call%0d", i), 1'b1, 16'(16'h1002 + i * 16'h0100), 1'b1, (i == 4), 1'b0);
    end
    for (int i = 0; i < 4; i++) begin
      drv(1'b1, 2'b11, 3'b111, 3'b000, 9'h000, 16'h0000, 16'h0000, 1'b0, 1'b0);
      cyc($sformatf("ret%0d", i), 1'b1, 16'(16'h1402 - i * 16'h0100), 1'b1, 1'b0, 1'b0);
    end
    cyc("ret_under", 1'b0, 16'h1104, 1'b0, 1'b1, 1'b0);
    idle();
    cyc("after_under", 1'b0, 16'h1106, 1'b0, 1'b0, 1'b0);

    // Wrap-around immediate target
    drv(1'b1, 2'b00, 3'b111, 3'b000, 9'h001, 16'h0000, 16'hFFFE, 1'b0, 1'b0);
    cyc("wrap", 1'b1, 16'h0002, 1'b1, 1'b0, 1'b0);

    // Stall holds everything, including stack and halt
    drv(1'b1, 2'b01, 3'b111, 3'b000, 9'h000, 16'hBEEF, 16'h0000, 1'b1, 1'b0);
    cyc("stall_br", 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0);
    drv(1'b1, 2'b01, 3'b111, 3'b000, 9'h000, 16'hBEEF, 16'h0000, 1'b1, 1'b1);
    cyc("stall_halt", 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0);
    drv(1'b1, 2'b10, 3'b111, 3'b000, 9'h000, 16'h0000, 16'h2000, 1'b1, 1'b0);
    cyc("stall_call", 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0);
    drv(1'b1, 2'b11, 3'b111, 3'b000, 9'h000, 16'h0000, 16'h0000, 1'b0, 1'b0);
    cyc("ret_nopush", 1'b0, 16'h0004, 1'b0, 1'b1, 1'b0);

    // Halt beats a branch and freezes pc until reset
    drv(1'b1, 2'b01, 3'b111, 3'b000, 9'h000, 16'hBEEF, 16'h0000, 1'b0, 1'b1);
    cyc("halt_br", 1'b0, 16'h0004, 1'b0, 1'b0, 1'b1);
    idle();
    cyc("halted1", 1'b0, 16'h0004, 1'b0, 1'b0, 1'b1);
    drv(1'b1, 2'b01, 3'b111, 3'b000, 9'h000, 16'hBEEF, 16'h0000, 1'b0, 1'b0);
    cyc("halted_br", 1'b0, 16'h0004, 1'b0, 1'b0, 1'b1);
    rst_n = 1'b0;
    idle();
    cyc("halt_rst", 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;

    // Reset mid-operation discards pushed return addresses
    drv(1'b1, 2'b10, 3'b111, 3'b000, 9'h000, 16'h0000, 16'h0500, 1'b0, 1'b0);
    cyc("call_pre", 1'b1, 16'h0502, 1'b1, 1'b0, 1'b0);
    rst_n = 1'b0;
    drv(1'b1, 2'b11, 3'b111, 3'b000, 9'h000, 16'h0000, 16'h0000, 1'b0, 1'b0);
    cyc("rst_ret", 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    cyc("ret_post", 1'b0, 16'h0002, 1'b0, 1'b1, 1'b0);

    chk("sb_drained", 32'(sb.size()), 32'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
